// File: rtl/itlb_ctrl_pkg.sv
// Shared types and sizing for the ITLB controller slice.
package itlb_ctrl_pkg;

  localparam int unsigned ITLB_ENTRY_SIZE = 32;
  localparam int unsigned MXLEN           = 32;
  localparam int unsigned VPN_W           = 20;

  typedef logic [MXLEN-1:0] pte_t;
  typedef logic [VPN_W-1:0] vpn_t;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    MISS_WAIT,
    REFILL
  } itlb_state_e;

  typedef struct packed {
    logic valid;
    vpn_t vpn;
  } ptw_req_t;

  typedef struct packed {
    logic valid;
    logic fault;
    pte_t pte;
  } ptw_resp_t;

endpackage

// File: rtl/itlb_ctrl_if.sv
// IFU request/response, entry-array enables and PTW handshake for the ITLB controller.
interface itlb_ctrl_if #(
  parameter int unsigned ENTRIES = 32,
  parameter int unsigned VPN_W   = 20,
  parameter int unsigned PTE_W   = 32
);
  logic               req_valid_i;
  logic               req_ready_o;
  logic [VPN_W-1:0]   req_vpn_i;
  logic               resp_valid_o;
  logic               resp_hit_o;
  logic               resp_fault_o;
  logic               resp_flushed_o;
  logic [ENTRIES-1:0] rd_en_o;
  logic [ENTRIES-1:0] wr_en_o;
  logic [PTE_W-1:0]   pte_wr_o;
  logic               ptw_req_valid_o;
  logic               ptw_req_ready_i;
  logic [VPN_W-1:0]   ptw_req_vpn_o;
  logic               ptw_resp_valid_i;
  logic [PTE_W-1:0]   ptw_resp_pte_i;
  logic               ptw_resp_fault_i;
  logic               flush_i;

  modport slave (
    input  req_valid_i, req_vpn_i, ptw_req_ready_i, ptw_resp_valid_i,
           ptw_resp_pte_i, ptw_resp_fault_i, flush_i,
    output req_ready_o, resp_valid_o, resp_hit_o, resp_fault_o, resp_flushed_o,
           rd_en_o, wr_en_o, pte_wr_o, ptw_req_valid_o, ptw_req_vpn_o
  );

  modport master (
    output req_valid_i, req_vpn_i, ptw_req_ready_i, ptw_resp_valid_i,
           ptw_resp_pte_i, ptw_resp_fault_i, flush_i,
    input  req_ready_o, resp_valid_o, resp_hit_o, resp_fault_o, resp_flushed_o,
           rd_en_o, wr_en_o, pte_wr_o, ptw_req_valid_o, ptw_req_vpn_o
  );
endinterface

// File: rtl/itlb_ctrl_victim_sel.sv
// Refill victim choice: lowest invalid entry, else a round-robin pointer.
module itlb_victim_sel #(
  parameter int unsigned ENTRIES = 32
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic [ENTRIES-1:0] valid,
  input  logic               fill,
  output logic [ENTRIES-1:0] victim
);
  localparam int unsigned PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [PTR_W-1:0] ptr;
  logic             full;
  logic             found;

  assign full = &valid;

  always_comb begin
    victim = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!found && !valid[i]) begin
        victim[i] = 1'b1;
        found     = 1'b1;
      end
    end
    if (!found) victim[ptr] = 1'b1;
  end

  // Pointer only advances when it actually supplied the victim.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) ptr <= '0;
    else if (fill && full) ptr <= (ptr == PTR_W'(ENTRIES - 1)) ? '0 : ptr + 1'b1;
  end
endmodule

// File: rtl/itlb_ctrl.sv
// ITLB controller: tag/valid store, fully-associative compare, PTW miss handling and flush.
module itlb_ctrl
  import itlb_ctrl_pkg::*;
#(
  parameter int unsigned ENTRIES = ITLB_ENTRY_SIZE,
  parameter int unsigned VPN_W   = itlb_ctrl_pkg::VPN_W,
  parameter int unsigned PTE_W   = MXLEN
) (
  input logic         clk_i,
  input logic         rstn_i,
  itlb_ctrl_if.slave  bus
);
  itlb_state_e        state, state_next;
  logic [ENTRIES-1:0] valid;
  logic [VPN_W-1:0]   tag [ENTRIES];
  logic [VPN_W-1:0]   vpn_q;
  logic [PTE_W-1:0]   pte_q;
  logic               flush_pending;
  logic [ENTRIES-1:0] hit_vec;
  logic [ENTRIES-1:0] victim;
  logic               accept;
  logic               fill;

  assign accept = bus.req_valid_i && bus.req_ready_o;
  assign fill   = (state == REFILL);

  itlb_victim_sel #(.ENTRIES(ENTRIES)) u_victim_sel (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .valid  (valid),
    .fill   (fill),
    .victim (victim)
  );

  always_comb begin
    hit_vec = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) hit_vec[i] = valid[i] && (tag[i] == vpn_q);
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (accept) state_next = LOOKUP;
      LOOKUP:    state_next = (|hit_vec) ? IDLE : MISS_REQ;
      MISS_REQ:  if (bus.ptw_req_ready_i) state_next = MISS_WAIT;
      MISS_WAIT: if (bus.ptw_resp_valid_i)
                   state_next = (bus.ptw_resp_fault_i || flush_pending) ? IDLE : REFILL;
      REFILL:    state_next = LOOKUP;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready_o     = (state == IDLE) && !bus.flush_i && !flush_pending;
    bus.resp_valid_o    = 1'b0;
    bus.resp_hit_o      = 1'b0;
    bus.resp_fault_o    = 1'b0;
    bus.resp_flushed_o  = 1'b0;
    bus.rd_en_o         = '0;
    bus.wr_en_o         = '0;
    bus.pte_wr_o        = '0;
    bus.ptw_req_valid_o = 1'b0;
    bus.ptw_req_vpn_o   = '0;
    case (state)
      LOOKUP: if (|hit_vec) begin
        bus.rd_en_o      = hit_vec;
        bus.resp_valid_o = 1'b1;
        bus.resp_hit_o   = 1'b1;
      end
      MISS_REQ: begin
        bus.ptw_req_valid_o = 1'b1;
        bus.ptw_req_vpn_o   = vpn_q;
      end
      MISS_WAIT: if (bus.ptw_resp_valid_i) begin
        if (bus.ptw_resp_fault_i) begin
          bus.resp_valid_o = 1'b1;
          bus.resp_fault_o = 1'b1;
        end else if (flush_pending) begin
          bus.resp_valid_o   = 1'b1;
          bus.resp_flushed_o = 1'b1;
        end
      end
      REFILL: begin
        bus.wr_en_o  = victim;
        bus.pte_wr_o = pte_q;
      end
      default: ;
    endcase
  end

  // A flush outside IDLE/LOOKUP is deferred and applied in the first IDLE cycle.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      valid         <= '0;
      flush_pending <= 1'b0;
      vpn_q         <= '0;
      pte_q         <= '0;
    end else begin
      if (accept) vpn_q <= bus.req_vpn_i;
      if (state == MISS_WAIT && bus.ptw_resp_valid_i) pte_q <= bus.ptw_resp_pte_i;
      case (state)
        IDLE: if (bus.flush_i || flush_pending) begin
          valid         <= '0;
          flush_pending <= 1'b0;
        end
        LOOKUP: if (bus.flush_i) valid <= '0;
        default: if (bus.flush_i) flush_pending <= 1'b1;
      endcase
      if (fill) valid <= valid | victim;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < ENTRIES; i++)
      if (fill && victim[i]) tag[i] <= vpn_q;
  end
endmodule

// File: doc/itlb_ctrl.md
Name: itlb_ctrl

Overview:
- Controller that sequences the ITLB entry array.
- Holds the VPN tag and valid bit for every entry and performs the fully-associative tag compare.
- Drives one-hot read enables on a hit and one-hot write enables on a refill. The PTE data path stays inside the entry array.
- Sits between the IFU translation request port and the page-table walker (PTW). Handles miss requests, victim selection and flush (sfence.vma).

Parameters:
- ENTRIES, `ITLB_ENTRY_SIZE (32): number of entries; sets the wr_en_o/rd_en_o width.
- VPN_W, 20: virtual page number width (Sv32).
- PTE_W, `MXLEN (32): PTE width.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset; synchronous, active-low, one clock
- req_valid_i  in  1  IFU lookup request
- req_ready_o  out  1  controller can accept a request
- req_vpn_i  in  VPN_W  lookup VPN
- resp_valid_o  out  1  one-cycle response strobe
- resp_hit_o  out  1  hit; PTE is on the array pte_rd_o in the same cycle
- resp_fault_o  out  1  PTW reported a page fault
- resp_flushed_o  out  1  request dropped by a flush; IFU must re-issue
- rd_en_o  out  ENTRIES  one-hot read enable to the entry array
- wr_en_o  out  ENTRIES  one-hot write enable to the entry array
- pte_wr_o  out  PTE_W  refill PTE to the entry array
- ptw_req_valid_o  out  1  walk request
- ptw_req_ready_i  in  1  PTW accepts the walk
- ptw_req_vpn_o  out  VPN_W  VPN to walk
- ptw_resp_valid_i  in  1  walk done
- ptw_resp_pte_i  in  PTE_W  leaf PTE
- ptw_resp_fault_i  in  1  walk fault
- flush_i  in  1  single-cycle invalidate-all pulse

Behaviour:
- Reset (rstn_i low at a clk_i edge):
  - state IDLE; all valid bits 0; round-robin pointer 0; flush_pending 0; latched VPN 0.
  - All outputs 0 except req_ready_o, which follows the IDLE equation.
  - Reset mid-walk abandons the walk. A late ptw_resp_valid_i arriving in IDLE is ignored.
- req_ready_o = (state==IDLE) & ~flush_i & ~flush_pending. Accept = req_valid_i & req_ready_o; the VPN is latched on accept.
- IDLE -> LOOKUP on accept.
- LOOKUP (exactly one cycle after accept):
  - Compare the latched VPN against all valid tags.
  - Hit: rd_en_o = one-hot hit index, resp_valid_o=1, resp_hit_o=1, next state IDLE. Hit latency is 1 cycle after accept.
  - Miss: rd_en_o=0, no response, next state MISS_REQ.
- MISS_REQ:
  - ptw_req_valid_o=1 and ptw_req_vpn_o = latched VPN, both held stable until ptw_req_ready_i.
  - Next state MISS_WAIT on handshake.
- MISS_WAIT: wait for ptw_resp_valid_i.
  - Fault: resp_valid_o=1, resp_fault_o=1, no write, next state IDLE.
  - flush_pending set: resp_valid_o=1, resp_flushed_o=1, no write, next state IDLE.
  - Otherwise next state REFILL, with the PTE latched.
- REFILL (one cycle):
  - wr_en_o = one-hot victim, pte_wr_o = latched PTE.
  - Tag[victim] = VPN and valid[victim] = 1 at the clock edge.
  - Next state LOOKUP (replay), which is guaranteed to hit. Miss-to-response latency is PTW latency + 2.
- Victim selection:
  - Lowest-index invalid entry if any exists.
  - Otherwise the round-robin pointer, which then increments and wraps from ENTRIES-1 to 0.
  - The pointer is unchanged when an invalid entry is used.
- Flush:
  - flush_i in IDLE or LOOKUP: every valid bit is cleared at the next edge.
  - A LOOKUP coinciding with flush_i completes against the pre-flush contents.
  - flush_i in MISS_REQ, MISS_WAIT or REFILL: sets flush_pending.
    - In REFILL the write still occurs but the entry is then invalidated.
    - The pending clear is applied on the next entry to IDLE, which also clears flush_pending.
    - req_ready_o stays 0 for that cycle.
- Invariants:
  - Multi-hit never occurs, because fills only follow misses.
  - rd_en_o and wr_en_o are never active in the same cycle.
  - At most one bit of each is set.

Decomposition:
- mms_pkg gains: VPN_W, the itlb_state_e enum (IDLE, LOOKUP, MISS_REQ, MISS_WAIT, REFILL), and the ptw request/response struct types. pte_t is reused.
- Sub-module itlb_victim_sel:
  - Inputs: valid vector, fill strobe.
  - Outputs: one-hot victim.
  - Owns the first-invalid priority encoder and the round-robin pointer.

Test Plan:
- Reset then request VPN 0x12345 -> miss, ptw_req_vpn_o=0x12345; PTW returns PTE 0x0ABCD0CF after 3 cycles -> wr_en_o=bit0, then LOOKUP rd_en_o=bit0, resp_hit_o=1; a second request for 0x12345 -> hit 1 cycle after accept.
- Fill 32 distinct VPNs -> wr_en_o walks bit0..bit31. 33rd miss -> victim bit0; 34th miss -> victim bit1 (round-robin wrap).
- PTW response with ptw_resp_fault_i=1 for VPN 0x00400 -> resp_fault_o=1, wr_en_o never asserted, next lookup of 0x00400 misses again.
- flush_i during MISS_WAIT, then PTW response -> resp_flushed_o=1, no write, all valid bits 0, req_ready_o low for one extra cycle.
- flush_i in the same cycle as a LOOKUP hit -> hit reported; the identical request afterwards misses.
- rstn_i low while ptw_req_valid_o=1 -> all outputs 0 the next cycle; a stray ptw_resp_valid_i is ignored; the previously filled VPN misses.
